// File: rtl/key_press_gen.sv
// Push-button emulator: drives a bouncing active-low key line on request.
// Optional press counter output enabled by defining KEY_PRESS_GEN_CNT_EN.
module key_press_gen #(
  parameter int unsigned BOUNCE_CNT     = 4,
  parameter int unsigned BOUNCE_MAX_CYC = 16,
  parameter int unsigned GAP_CYC        = 8,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] hold_len,
  output logic        key_out,
  output logic        busy,
  output logic        done
`ifdef KEY_PRESS_GEN_CNT_EN
  ,
  output logic [15:0] press_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_B,
    HOLD,
    REL_B,
    GAP
  } state_e;

  localparam logic [15:0] SEED =
    (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [7:0] LEN_MASK = 8'(BOUNCE_MAX_CYC - 1);
  localparam logic [8:0] LAST_EDGE = 9'(2 * BOUNCE_CNT - 1);
  localparam logic [31:0] GAP_LAST = 32'(GAP_CYC - 1);
  localparam bit NO_BOUNCE = (BOUNCE_CNT == 0);

  state_e      state_q;
  logic        key_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic [7:0]  seg_q;
  logic [7:0]  seg_d;
  logic [8:0]  edge_q;
  logic [31:0] cnt_q;
  logic [31:0] hold_q;
  logic [31:0] hold_d;
  logic        fin;

  // Segment length is drawn from the LFSR value before it advances.
  always_comb begin
    lfsr_d = {lfsr_q[14:0],
              lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    seg_d  = lfsr_q[7:0] & LEN_MASK;
    hold_d = (hold_len == 32'd0) ? 32'd1 : hold_len;
    fin    = (state_q == GAP) && (cnt_q == 32'd0) && !abort;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lfsr_q  <= SEED;
      seg_q   <= 8'd0;
      edge_q  <= 9'd0;
      cnt_q   <= 32'd0;
      hold_q  <= 32'd0;
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE && abort) begin
        state_q <= IDLE;
        key_q   <= 1'b1;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start && !abort && !done_q) begin
              hold_q <= hold_d;
              busy_q <= 1'b1;
              key_q  <= 1'b0;
              if (NO_BOUNCE) begin
                state_q <= HOLD;
                cnt_q   <= hold_d - 32'd1;
              end else begin
                state_q <= PRESS_B;
                seg_q   <= seg_d;
                lfsr_q  <= lfsr_d;
                edge_q  <= 9'd0;
              end
            end
          end
          PRESS_B: begin
            if (seg_q != 8'd0) begin
              seg_q <= seg_q - 8'd1;
            end else if (edge_q == LAST_EDGE) begin
              state_q <= HOLD;
              key_q   <= 1'b0;
              cnt_q   <= hold_q - 32'd1;
            end else begin
              edge_q <= edge_q + 9'd1;
              key_q  <= ~key_q;
              seg_q  <= seg_d;
              lfsr_q <= lfsr_d;
            end
          end
          HOLD: begin
            if (cnt_q != 32'd0) begin
              cnt_q <= cnt_q - 32'd1;
            end else begin
              key_q <= 1'b1;
              if (NO_BOUNCE) begin
                state_q <= GAP;
                cnt_q   <= GAP_LAST;
              end else begin
                state_q <= REL_B;
                seg_q   <= seg_d;
                lfsr_q  <= lfsr_d;
                edge_q  <= 9'd0;
              end
            end
          end
          REL_B: begin
            if (seg_q != 8'd0) begin
              seg_q <= seg_q - 8'd1;
            end else if (edge_q == LAST_EDGE) begin
              state_q <= GAP;
              key_q   <= 1'b1;
              cnt_q   <= GAP_LAST;
            end else begin
              edge_q <= edge_q + 9'd1;
              key_q  <= ~key_q;
              seg_q  <= seg_d;
              lfsr_q <= lfsr_d;
            end
          end
          GAP: begin
            if (cnt_q != 32'd0) begin
              cnt_q <= cnt_q - 32'd1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
            key_q   <= 1'b1;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef KEY_PRESS_GEN_CNT_EN
  logic [15:0] pcnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q <= 16'd0;
    end else if (fin) begin
      pcnt_q <= pcnt_q + 16'd1;
    end
  end

  assign press_cnt = pcnt_q;
`endif

  assign key_out = key_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_key_press_gen.sv
// Bench for key_press_gen: phase-level reference model, random and directed stimulus.
// Two instances share inputs: one bouncing (defaults), one with clean edges.
module tb_key_press_gen;

  localparam int BMAX = 16;
  localparam int GAPC = 8;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] hold_len = 32'd0;
  logic        kb, bb, db, kc, bc, dc;
`ifdef KEY_PRESS_GEN_CNT_EN
  logic [15:0] pcb, pcc;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  key_press_gen u_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .hold_len(hold_len), .key_out(kb), .busy(bb), .done(db)
`ifdef KEY_PRESS_GEN_CNT_EN
    , .press_cnt(pcb)
`endif
  );

  key_press_gen #(.BOUNCE_CNT(0)) u_c (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .hold_len(hold_len), .key_out(kc), .busy(bc), .done(dc)
`ifdef KEY_PRESS_GEN_CNT_EN
    , .press_cnt(pcc)
`endif
  );

  // Reference model: a press is a list of phases (bounce segments,
  // hold, bounce segments, gap); each phase has a level and a length.
  int          bcnt [2] = '{4, 0};
  bit          m_busy [2] = '{1'b0, 1'b0};
  bit          m_key [2] = '{1'b1, 1'b1};
  bit          m_done [2] = '{1'b0, 1'b0};
  logic [15:0] m_lfsr [2] = '{SEED, SEED};
  logic [15:0] m_pc [2] = '{16'd0, 16'd0};
  longint      m_hold [2];
  longint      m_rem [2];
  int          m_ph [2];

  task automatic draw(input int i);
    logic [15:0] l;
    l = m_lfsr[i];
    m_rem[i] = longint'(l[7:0] & 8'(BMAX - 1)) + 1;
    m_lfsr[i] = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endtask

  task automatic begin_phase(input int i);
    int p, b;
    p = m_ph[i];
    b = bcnt[i];
    if (p < 2 * b) begin
      m_key[i] = (p % 2 == 1);
      draw(i);
    end else if (p == 2 * b) begin
      m_key[i] = 1'b0;
      m_rem[i] = m_hold[i];
    end else if (p < 4 * b + 1) begin
      m_key[i] = ((p - 2 * b - 1) % 2 == 0);
      draw(i);
    end else begin
      m_key[i] = 1'b1;
      m_rem[i] = GAPC;
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_busy[i] = 1'b0;
        m_key[i]  = 1'b1;
        m_done[i] = 1'b0;
        m_lfsr[i] = SEED;
        m_pc[i]   = 16'd0;
      end else begin
        bit prev_done;
        prev_done = m_done[i];
        m_done[i] = 1'b0;
        if (m_busy[i]) begin
          if (abort) begin
            m_busy[i] = 1'b0;
            m_key[i]  = 1'b1;
          end else if (m_rem[i] > 1) begin
            m_rem[i]--;
          end else if (m_ph[i] == 4 * bcnt[i] + 1) begin
            m_busy[i] = 1'b0;
            m_key[i]  = 1'b1;
            m_done[i] = 1'b1;
            m_pc[i]   = m_pc[i] + 16'd1;
          end else begin
            m_ph[i]++;
            begin_phase(i);
          end
        end else if (start && !abort && !prev_done) begin
          m_hold[i] = (hold_len == 32'd0) ? 1 : longint'(hold_len);
          m_busy[i] = 1'b1;
          m_ph[i]   = 0;
          begin_phase(i);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    n_cmp++;
    if ({kb, bb, db} !== {m_key[0], m_busy[0], m_done[0]}) begin
      n_bad++;
      $display("FAIL bounce_outputs t=%0t key/busy/done got %b%b%b want %b%b%b",
               $time, kb, bb, db, m_key[0], m_busy[0], m_done[0]);
    end
    n_cmp++;
    if ({kc, bc, dc} !== {m_key[1], m_busy[1], m_done[1]}) begin
      n_bad++;
      $display("FAIL clean_outputs t=%0t key/busy/done got %b%b%b want %b%b%b",
               $time, kc, bc, dc, m_key[1], m_busy[1], m_done[1]);
    end
`ifdef KEY_PRESS_GEN_CNT_EN
    n_cmp++;
    if (pcb !== m_pc[0] || pcc !== m_pc[1]) begin
      n_bad++;
      $display("FAIL press_cnt t=%0t got %0d/%0d want %0d/%0d",
               $time, pcb, pcc, m_pc[0], m_pc[1]);
    end
`endif
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  // Length of the current key_out run (sampled now) on instance sel.
  task automatic run_len(input int sel, output int n);
    logic lvl;
    lvl = (sel == 0) ? kb : kc;
    n = 1;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      #1;
      if (((sel == 0) ? kb : kc) == lvl) n++;
      else break;
    end
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 5000; k++) begin
      @(posedge clk);
      #1;
      if (!bb && !bc && !db && !dc) break;
    end
    chk("idle_timeout", longint'(k >= 5000), 0);
  endtask

  task automatic press(input logic [31:0] h);
    @(negedge clk);
    hold_len = h;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("reset_key", kb, 1);
    chk("reset_busy", bb, 0);
    chk("reset_done", db, 0);
    rst = 1'b0;

    press(50);
    chk("start_busy", bb, 1);
    run_len(0, n); chk("seg1_len", n, 2);
    run_len(0, n); chk("seg2_len", n, 4);
    run_len(0, n); chk("seg3_len", n, 8);
    wait_idle();

    press(100);
    run_len(1, n); chk("clean_hold", n, 100);
    n = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      #1;
      n++;
      if (dc) break;
    end
    chk("clean_gap_to_done", n, 8);
    wait_idle();

    press(1000);
    repeat (400) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_key", kb, 1);
    chk("abort_busy", bb, 0);
    chk("abort_clean_busy", bc, 0);
    repeat (30) @(posedge clk);

    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    hold_len = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle", bb, 0);

    press(20);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      start = (k % 2 == 0);
      hold_len = 32'd500;
    end
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    press(30);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mid_key", kb, 1);
    chk("rst_mid_busy", bb, 0);
    press(30);
    run_len(0, n); chk("rst_seg1_len", n, 2);
    run_len(0, n); chk("rst_seg2_len", n, 4);
    run_len(0, n); chk("rst_seg3_len", n, 8);
    wait_idle();

    press(0);
    wait_idle();

`ifdef KEY_PRESS_GEN_CNT_EN
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      press(32'(10 + k));
      wait_idle();
    end
    press(200);
    repeat (150) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_idle();
    chk("press_cnt_3", pcb, 3);
`endif

    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      start = ($urandom % 8 == 0);
      abort = ($urandom % 300 == 0);
      rst = ($urandom % 3000 == 0);
      hold_len = ($urandom % 16 == 0) ? 32'd0 : 32'($urandom_range(1, 40));
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    rst = 1'b0;
    wait_idle();
    repeat (4) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
